// File: rtl/tcp_vlg_tx_info.sv
// -----------------------------------------------------------------------------
// tcp_vlg_tx_info
// Packet information table for the TCP transmit path.
//
// The table stores packet descriptors in a circular buffer and offers them to
// the TX engine over a valid/ready port. It sends each packet once, and
// retransmits the head packet when no ACK progress is seen for RTO_TICKS
// cycles. Cumulative ACKs free entries from the head.
//
// Ports
//   clk_i      : clock, rising edge
//   rst_ni     : synchronous reset, active low
//   flush_i    : clear the table and all scheduling state
//   add_i      : store pkt_i (one-cycle request)
//   pkt_i      : descriptor to store (tries field ignored)
//   ack_val_i  : ack_i is valid this cycle
//   ack_i      : cumulative acknowledgement number
//   out_val_o  : out_pkt_o is offered to the TX engine
//   out_rdy_i  : TX engine accepts out_pkt_o
//   out_pkt_o  : descriptor to transmit, tries = 1-based transmission ordinal
//   full_o     : table holds DEPTH entries
//   empty_o    : table holds no entries
//   dead_o     : sticky, head packet exhausted MAX_TRIES transmissions
// -----------------------------------------------------------------------------
package tcp_vlg_tx_info_pkg;
   typedef logic [31:0] tcp_num_t;

   typedef struct packed {
      tcp_num_t    start;
      tcp_num_t    stop;
      logic [15:0] length;
      logic [15:0] cks;
      logic [3:0]  tries;
   } tcp_pkt_t;
endpackage

module tcp_vlg_tx_info
   import tcp_vlg_tx_info_pkg::*;
#(
   parameter int DEPTH     = 8,
   parameter int RTO_TICKS = 2500,
   parameter int MAX_TRIES = 5
) (
   input  logic     clk_i,
   input  logic     rst_ni,
   input  logic     flush_i,
   input  logic     add_i,
   input  tcp_pkt_t pkt_i,
   input  logic     ack_val_i,
   input  tcp_num_t ack_i,
   output logic     out_val_o,
   input  logic     out_rdy_i,
   output tcp_pkt_t out_pkt_o,
   output logic     full_o,
   output logic     empty_o,
   output logic     dead_o
);
   localparam int AW = $clog2(DEPTH);
   localparam int PW = AW + 1;
   localparam int TW = $clog2(RTO_TICKS + 1);

   typedef logic [PW-1:0] ptr_t;
   typedef enum logic [1:0] {S_IDLE, S_SEND, S_RTX} state_t;

   localparam ptr_t          DEPTH_P = PW'(DEPTH);
   localparam logic [TW-1:0] RTO_T   = TW'(RTO_TICKS);
   localparam logic [3:0]    MAX_T   = 4'(MAX_TRIES);

   tcp_pkt_t   mem_q   [DEPTH];
   logic [3:0] tries_q [DEPTH];

   state_t        state_q, state_d;
   tcp_pkt_t      out_pkt_q, out_pkt_d;
   ptr_t          rd_ptr_q, rd_ptr_d;
   ptr_t          snd_ptr_q, snd_ptr_d;
   ptr_t          wr_ptr_q, wr_ptr_d;
   ptr_t          cur_ptr_q, cur_ptr_d;     // entry currently offered
   logic [TW-1:0] timer_q, timer_d;
   logic          dead_q, dead_d;
   tcp_num_t      ack_q, ack_d;
   logic          ack_seen_q, ack_seen_d;  // ack_q holds a real ACK

   ptr_t       count;
   tcp_pkt_t   head_pkt;
   logic [3:0] head_tries;
   tcp_num_t   ack_diff;
   logic       purge;
   logic       add_go;
   logic       timeout;
   logic       cur_live;
   logic       wb_en;

   assign count      = wr_ptr_q - rd_ptr_q;
   assign full_o     = (count == DEPTH_P);
   assign empty_o    = (count == '0);
   assign head_pkt   = mem_q[rd_ptr_q[AW-1:0]];
   assign head_tries = tries_q[rd_ptr_q[AW-1:0]];
   // Modular sequence compare: acked when ack - stop is non-negative.
   assign ack_diff   = ack_q - head_pkt.stop;
   assign purge      = ack_seen_q && !empty_o && !ack_diff[31];
   assign add_go     = add_i && !full_o && !flush_i;
   assign timeout    = !empty_o && (timer_q == RTO_T);
   // A purged offered entry lies behind rd_ptr, so its offset wraps past count.
   assign cur_live   = ((cur_ptr_q - rd_ptr_q) < count);

   assign out_val_o  = (state_q != S_IDLE);
   assign out_pkt_o  = out_pkt_q;
   assign dead_o     = dead_q;

   always_comb begin
      state_d    = state_q;
      out_pkt_d  = out_pkt_q;
      rd_ptr_d   = rd_ptr_q;
      snd_ptr_d  = snd_ptr_q;
      wr_ptr_d   = wr_ptr_q;
      cur_ptr_d  = cur_ptr_q;
      timer_d    = timer_q;
      dead_d     = dead_q;
      ack_d      = ack_q;
      ack_seen_d = ack_seen_q;
      wb_en      = 1'b0;

      if (ack_val_i) begin
         ack_d      = ack_i;
         ack_seen_d = 1'b1;
      end

      if (add_go) begin
         wr_ptr_d = wr_ptr_q + PW'(1);
      end

      if (!empty_o && head_tries != 4'd0 && state_q == S_IDLE && timer_q != RTO_T) begin
         timer_d = timer_q + TW'(1);
      end

      if (timeout && head_tries == MAX_T) begin
         dead_d = 1'b1;
      end

      case (state_q)
         S_IDLE: begin
            // Nothing is loaded in a purge cycle so an entry being freed is never offered.
            if (!purge) begin
               if (timeout && !dead_q && head_tries < MAX_T) begin
                  state_d         = S_RTX;
                  out_pkt_d       = head_pkt;
                  out_pkt_d.tries = head_tries + 4'd1;
                  cur_ptr_d       = rd_ptr_q;
               end else if (snd_ptr_q != wr_ptr_q) begin
                  state_d         = S_SEND;
                  out_pkt_d       = mem_q[snd_ptr_q[AW-1:0]];
                  out_pkt_d.tries = 4'd1;
                  cur_ptr_d       = snd_ptr_q;
               end
            end
         end
         default: begin
            if (out_rdy_i) begin
               state_d = S_IDLE;
               wb_en   = cur_live;
               if (cur_ptr_q == rd_ptr_q) begin
                  timer_d = '0;
               end
               // If a purge already moved snd_ptr past this entry, leave it.
               if (state_q == S_SEND && snd_ptr_q == cur_ptr_q) begin
                  snd_ptr_d = snd_ptr_q + PW'(1);
               end
            end
         end
      endcase

      if (purge) begin
         rd_ptr_d = rd_ptr_q + PW'(1);
         timer_d  = '0;
         if (snd_ptr_d == rd_ptr_q) begin
            snd_ptr_d = rd_ptr_q + PW'(1);
         end
      end

      if (flush_i) begin
         state_d    = S_IDLE;
         rd_ptr_d   = '0;
         snd_ptr_d  = '0;
         wr_ptr_d   = '0;
         cur_ptr_d  = '0;
         timer_d    = '0;
         dead_d     = 1'b0;
         ack_seen_d = 1'b0;   // stale ACKs must not free packets added after a flush
         wb_en      = 1'b0;
      end
   end

   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         state_q    <= S_IDLE;
         out_pkt_q  <= '0;
         rd_ptr_q   <= '0;
         snd_ptr_q  <= '0;
         wr_ptr_q   <= '0;
         cur_ptr_q  <= '0;
         timer_q    <= '0;
         dead_q     <= 1'b0;
         ack_q      <= '0;
         ack_seen_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         out_pkt_q  <= out_pkt_d;
         rd_ptr_q   <= rd_ptr_d;
         snd_ptr_q  <= snd_ptr_d;
         wr_ptr_q   <= wr_ptr_d;
         cur_ptr_q  <= cur_ptr_d;
         timer_q    <= timer_d;
         dead_q     <= dead_d;
         ack_q      <= ack_d;
         ack_seen_q <= ack_seen_d;
      end
   end

   // Table storage; a new entry's tries write wins over any writeback.
   always_ff @(posedge clk_i) begin
      if (rst_ni) begin
         if (wb_en) begin
            tries_q[cur_ptr_q[AW-1:0]] <= out_pkt_q.tries;
         end
         if (add_go) begin
            mem_q[wr_ptr_q[AW-1:0]]   <= pkt_i;
            tries_q[wr_ptr_q[AW-1:0]] <= 4'd0;
         end
      end
   end

   always @(posedge clk_i) begin
      if (rst_ni && !flush_i && add_i) begin
         assert (!full_o) else $warning("tcp_vlg_tx_info: add request while full was dropped");
      end
   end
endmodule

// File: tb/tb_tcp_vlg_tx_info.sv
// -----------------------------------------------------------------------------
// tb_tcp_vlg_tx_info
// Scoreboard bench: expected offers are queued when stimulus is driven and
// popped when the TX engine accepts an offer. Inputs are driven at the
// falling edge; outputs are observed at the falling edge.
// -----------------------------------------------------------------------------
module tb_tcp_vlg_tx_info;
   import tcp_vlg_tx_info_pkg::*;

   localparam int DEPTH = 8;
   localparam int RTO   = 20;
   localparam int MAXT  = 5;

   logic     clk = 1'b0;
   logic     rst_n, flush, add, ack_val, out_rdy;
   tcp_pkt_t pkt, out_pkt;
   tcp_num_t ack;
   logic     out_val, full, empty, dead;

   int checks = 0;
   int errors = 0;
   int cyc    = 0;

   tcp_pkt_t exp_q[$];
   int       acc_cyc_q[$];

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   tcp_vlg_tx_info #(.DEPTH(DEPTH), .RTO_TICKS(RTO), .MAX_TRIES(MAXT)) dut (
      .clk_i     (clk),
      .rst_ni    (rst_n),
      .flush_i   (flush),
      .add_i     (add),
      .pkt_i     (pkt),
      .ack_val_i (ack_val),
      .ack_i     (ack),
      .out_val_o (out_val),
      .out_rdy_i (out_rdy),
      .out_pkt_o (out_pkt),
      .full_o    (full),
      .empty_o   (empty),
      .dead_o    (dead)
   );

   function automatic tcp_pkt_t mk(input logic [31:0] stop, input logic [3:0] tries);
      tcp_pkt_t p;
      p.start  = stop - 32'd100;
      p.stop   = stop;
      p.length = 16'd100;
      p.cks    = stop[15:0] ^ 16'hA5A5;
      p.tries  = tries;
      return p;
   endfunction

   // Advance one cycle. An accept happens when out_val and out_rdy are both
   // high ahead of the coming rising edge; the scoreboard is consumed there.
   task automatic step();
      tcp_pkt_t e;
      if (rst_n && out_val && out_rdy) begin
         checks++;
         if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL offer_unexpected: got stop=%h tries=%0d, expected no offer", out_pkt.stop, out_pkt.tries);
         end else begin
            e = exp_q.pop_front();
            if (out_pkt !== e) begin
               errors++;
               $display("FAIL offer_pkt: got stop=%h tries=%0d start=%h, expected stop=%h tries=%0d start=%h",
                        out_pkt.stop, out_pkt.tries, out_pkt.start, e.stop, e.tries, e.start);
            end
         end
         acc_cyc_q.push_back(cyc);
         $display("accept cycle %0d stop=%h tries=%0d", cyc, out_pkt.stop, out_pkt.tries);
      end
      @(negedge clk);
   endtask

   task automatic drain(input int budget);
      for (int i = 0; i < budget && exp_q.size() != 0; i++) step();
   endtask

   task automatic do_flush();
      flush = 1'b1;
      step();
      flush = 1'b0;
   endtask

   task automatic send_ack(input logic [31:0] a, input int wait_cycles);
      ack_val = 1'b1;
      ack     = a;
      step();
      ack_val = 1'b0;
      repeat (wait_cycles) step();
   endtask

   task automatic test_reset();
      rst_n = 1'b0; flush = 1'b0; add = 1'b0; ack_val = 1'b0; out_rdy = 1'b0;
      pkt = '0; ack = '0;
      @(negedge clk);
      repeat (3) step();
      checks++;
      if (empty !== 1'b1 || out_val !== 1'b0 || dead !== 1'b0 || full !== 1'b0 || out_pkt !== '0) begin
         errors++;
         $display("FAIL reset_state: got empty=%b out_val=%b dead=%b full=%b out_pkt=%h, expected 1 0 0 0 0",
                  empty, out_val, dead, full, out_pkt);
      end
      rst_n = 1'b1;
      step();
   endtask

   task automatic test_send_order();
      out_rdy = 1'b1;
      exp_q.push_back(mk(32'd100, 4'd1));
      exp_q.push_back(mk(32'd200, 4'd1));
      exp_q.push_back(mk(32'd300, 4'd1));
      add = 1'b1; pkt = mk(32'd100, 4'd0);
      step();
      checks++;
      if (empty !== 1'b0 || out_val !== 1'b0) begin
         errors++;
         $display("FAIL add_latency_n1: got empty=%b out_val=%b, expected empty=0 out_val=0", empty, out_val);
      end
      pkt = mk(32'd200, 4'd0);
      step();
      checks++;
      if (out_val !== 1'b1 || out_pkt.stop !== 32'd100) begin
         errors++;
         $display("FAIL add_latency_n2: got out_val=%b stop=%0d, expected out_val=1 stop=100", out_val, out_pkt.stop);
      end
      pkt = mk(32'd300, 4'd0);
      step();
      add = 1'b0;
      drain(40);
      checks++;
      if (exp_q.size() != 0) begin
         errors++;
         $display("FAIL send_drain: got %0d offers outstanding, expected 0", exp_q.size());
      end
      send_ack(32'd300, 5);
      checks++;
      if (empty !== 1'b1) begin
         errors++;
         $display("FAIL send_ack_empty: got empty=%b, expected 1", empty);
      end
   endtask

   task automatic test_full_drop();
      do_flush();
      out_rdy = 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
         add = 1'b1; pkt = mk(32'd1000 + 32'(i) * 32'd100, 4'd0);
         step();
      end
      add = 1'b0;
      checks++;
      if (full !== 1'b1 || out_val !== 1'b1 || out_pkt.stop !== 32'd1000) begin
         errors++;
         $display("FAIL full_set: got full=%b out_val=%b stop=%0d, expected full=1 out_val=1 stop=1000", full, out_val, out_pkt.stop);
      end
      add = 1'b1; pkt = mk(32'd1800, 4'd0);
      step();
      add = 1'b0;
      checks++;
      if (full !== 1'b1) begin
         errors++;
         $display("FAIL full_after_drop: got full=%b, expected 1", full);
      end
      // ACK in cycle M: first entry freed at the edge ending M+1, so full
      // is still set in M+1 and falls in M+2.
      send_ack(32'd1200, 0);
      checks++;
      if (full !== 1'b1) begin
         errors++;
         $display("FAIL full_ack_n1: got full=%b, expected 1", full);
      end
      step();
      checks++;
      if (full !== 1'b0) begin
         errors++;
         $display("FAIL full_ack_n2: got full=%b, expected 0", full);
      end
      repeat (3) step();
      checks++;
      if (empty !== 1'b0 || full !== 1'b0 || out_pkt.stop !== 32'd1000 || out_val !== 1'b1) begin
         errors++;
         $display("FAIL full_three_freed: got empty=%b full=%b stop=%0d out_val=%b, expected 0 0 1000 1",
                  empty, full, out_pkt.stop, out_val);
      end
      exp_q.push_back(mk(32'd1000, 4'd1));
      for (int i = 3; i < DEPTH; i++) exp_q.push_back(mk(32'd1000 + 32'(i) * 32'd100, 4'd1));
      out_rdy = 1'b1;
      drain(60);
      checks++;
      if (exp_q.size() != 0) begin
         errors++;
         $display("FAIL full_drain: got %0d offers outstanding, expected 0", exp_q.size());
      end
      send_ack(32'd1700, 10);
      checks++;
      if (empty !== 1'b1) begin
         errors++;
         $display("FAIL full_drop_empty: got empty=%b, expected 1 (dropped add must not be stored)", empty);
      end
   endtask

   task automatic test_retransmit();
      int a5;
      do_flush();
      out_rdy = 1'b1;
      acc_cyc_q.delete();
      for (int t = 1; t <= MAXT; t++) exp_q.push_back(mk(32'd500, 4'(t)));
      add = 1'b1; pkt = mk(32'd500, 4'd0);
      step();
      add = 1'b0;
      for (int i = 0; i < 200 && acc_cyc_q.size() < MAXT; i++) step();
      checks++;
      if (acc_cyc_q.size() != MAXT) begin
         errors++;
         $display("FAIL rtx_count: got %0d transmissions, expected %0d", acc_cyc_q.size(), MAXT);
      end else begin
         // Accept in cycle A: timer counts in A+1..A+RTO, reaches RTO in
         // A+RTO+1, RTX loads at that edge, offered and accepted in A+RTO+2.
         for (int i = 1; i < MAXT; i++) begin
            checks++;
            if (acc_cyc_q[i] - acc_cyc_q[i-1] != RTO + 2) begin
               errors++;
               $display("FAIL rtx_interval: got %0d cycles between tries %0d and %0d, expected %0d",
                        acc_cyc_q[i] - acc_cyc_q[i-1], i, i + 1, RTO + 2);
            end
         end
         a5 = acc_cyc_q[MAXT-1];
         for (int i = 0; i < 60 && cyc < a5 + RTO + 1; i++) step();
         checks++;
         if (dead !== 1'b0) begin
            errors++;
            $display("FAIL dead_early: got dead=%b at cycle %0d, expected 0", dead, cyc);
         end
         step();
         checks++;
         if (dead !== 1'b1) begin
            errors++;
            $display("FAIL dead_set: got dead=%b at cycle %0d, expected 1", dead, cyc);
         end
      end
      repeat (30) step();
      checks++;
      if (out_val !== 1'b0 || dead !== 1'b1) begin
         errors++;
         $display("FAIL dead_no_offer: got out_val=%b dead=%b, expected 0 1", out_val, dead);
      end
      send_ack(32'd500, 4);
      checks++;
      if (empty !== 1'b1 || dead !== 1'b1) begin
         errors++;
         $display("FAIL dead_sticky: got empty=%b dead=%b, expected 1 1", empty, dead);
      end
      out_rdy = 1'b0;
   endtask

   task automatic test_flush();
      out_rdy = 1'b0;
      for (int i = 0; i < 4; i++) begin
         add = 1'b1; pkt = mk(32'd2000 + 32'(i) * 32'd100, 4'd0);
         step();
      end
      add = 1'b0;
      step();
      checks++;
      if (out_val !== 1'b1 || out_pkt.stop !== 32'd2000 || dead !== 1'b1) begin
         errors++;
         $display("FAIL send_while_dead: got out_val=%b stop=%0d dead=%b, expected 1 2000 1", out_val, out_pkt.stop, dead);
      end
      flush = 1'b1; add = 1'b1; pkt = mk(32'd9999, 4'd0);
      step();
      flush = 1'b0; add = 1'b0;
      checks++;
      if (out_val !== 1'b0 || empty !== 1'b1 || dead !== 1'b0 || full !== 1'b0) begin
         errors++;
         $display("FAIL flush_state: got out_val=%b empty=%b dead=%b full=%b, expected 0 1 0 0", out_val, empty, dead, full);
      end
      repeat (3) step();
      checks++;
      if (out_val !== 1'b0 || empty !== 1'b1) begin
         errors++;
         $display("FAIL flush_add_ignored: got out_val=%b empty=%b, expected 0 1", out_val, empty);
      end
   endtask

   task automatic test_purge_offered();
      out_rdy = 1'b0;
      add = 1'b1; pkt = mk(32'd700, 4'd0);
      step();
      add = 1'b0;
      step();
      checks++;
      if (out_val !== 1'b1 || out_pkt.stop !== 32'd700) begin
         errors++;
         $display("FAIL purge_offer_up: got out_val=%b stop=%0d, expected 1 700", out_val, out_pkt.stop);
      end
      send_ack(32'd700, 3);
      checks++;
      if (empty !== 1'b1 || out_val !== 1'b1 || out_pkt !== mk(32'd700, 4'd1)) begin
         errors++;
         $display("FAIL purge_offer_stable: got empty=%b out_val=%b stop=%0d tries=%0d, expected 1 1 700 1",
                  empty, out_val, out_pkt.stop, out_pkt.tries);
      end
      exp_q.push_back(mk(32'd700, 4'd1));
      out_rdy = 1'b1;
      step();
      out_rdy = 1'b0;
      checks++;
      if (exp_q.size() != 0 || out_val !== 1'b0 || empty !== 1'b1) begin
         errors++;
         $display("FAIL purge_offer_accept: got outstanding=%0d out_val=%b empty=%b, expected 0 0 1",
                  exp_q.size(), out_val, empty);
      end
   endtask

   task automatic test_wrap();
      do_flush();
      out_rdy = 1'b1;
      exp_q.push_back(mk(32'hFFFF_FFF0, 4'd1));
      exp_q.push_back(mk(32'h0000_0020, 4'd1));
      add = 1'b1; pkt = mk(32'hFFFF_FFF0, 4'd0);
      step();
      pkt = mk(32'h0000_0020, 4'd0);
      step();
      add = 1'b0;
      drain(20);
      checks++;
      if (exp_q.size() != 0 || empty !== 1'b0) begin
         errors++;
         $display("FAIL wrap_send: got outstanding=%0d empty=%b, expected 0 0", exp_q.size(), empty);
      end
      send_ack(32'hFFFF_FFF0, 4);
      checks++;
      if (empty !== 1'b0) begin
         errors++;
         $display("FAIL wrap_partial: got empty=%b, expected 0", empty);
      end
      send_ack(32'h0000_0020, 4);
      checks++;
      if (empty !== 1'b1) begin
         errors++;
         $display("FAIL wrap_both_freed: got empty=%b, expected 1", empty);
      end
      out_rdy = 1'b0;
   endtask

   initial begin
      test_reset();
      test_send_order();
      test_full_drop();
      test_retransmit();
      test_flush();
      test_purge_offered();
      test_wrap();
      repeat (2) step();
      checks++;
      if (exp_q.size() != 0) begin
         errors++;
         $display("FAIL scoreboard_residue: got %0d offers outstanding, expected 0", exp_q.size());
      end
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
